// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register for the 5-stage RV32 core.
// Holds on stall, inserts an all-zero bubble on flush, and counts inserted bubbles.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic                      ALUSrcD,
  input  logic                      ALUSrcAD,
  input  logic                      SumSrcD,
  input  logic                      ControlSignalD,
  input  logic [3:0]                ALUControlD,
  input  logic [1:0]                StoreSrcD,
  input  logic [2:0]                TypeBranchD,
  input  logic [2:0]                LoadSrcD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic [1:0]                ResultSrcE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic                      ALUSrcAE,
  output logic                      SumSrcE,
  output logic                      ControlSignalE,
  output logic [3:0]                ALUControlE,
  output logic [1:0]                StoreSrcE,
  output logic [2:0]                TypeBranchE,
  output logic [2:0]                LoadSrcE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic                      ValidE,
  output logic [CNT_WIDTH-1:0]      BubbleCountE
);

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_write;
    logic [1:0]                result_src;
    logic                      jump;
    logic                      branch;
    logic                      alu_src;
    logic                      alu_src_a;
    logic                      sum_src;
    logic                      control_signal;
    logic [3:0]                alu_control;
    logic [1:0]                store_src;
    logic [2:0]                type_branch;
    logic [2:0]                load_src;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic                      valid;
  } stage_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  stage_t               stage_d, stage_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;
  logic                 load_bubble;

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    load_bubble  = 1'b0;
    if (FlushE) begin
      stage_d     = '0;
      load_bubble = 1'b1;
    end else if (!StallE) begin
      stage_d.reg_write      = RegWriteD;
      stage_d.mem_write      = MemWriteD;
      stage_d.result_src     = ResultSrcD;
      stage_d.jump           = JumpD;
      stage_d.branch         = BranchD;
      stage_d.alu_src        = ALUSrcD;
      stage_d.alu_src_a      = ALUSrcAD;
      stage_d.sum_src        = SumSrcD;
      stage_d.control_signal = ControlSignalD;
      stage_d.alu_control    = ALUControlD;
      stage_d.store_src      = StoreSrcD;
      stage_d.type_branch    = TypeBranchD;
      stage_d.load_src       = LoadSrcD;
      stage_d.rd1            = RD1D;
      stage_d.rd2            = RD2D;
      stage_d.rs1            = Rs1D;
      stage_d.rs2            = Rs2D;
      stage_d.rd             = RdD;
      stage_d.pc             = PCD;
      stage_d.pc_plus4       = PCPlus4D;
      stage_d.imm_ext        = ImmExtD;
      stage_d.valid          = ValidD;
      load_bubble            = !ValidD;
    end
    // Saturate rather than wrap so a long-running counter never reads low.
    if (load_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign RegWriteE      = stage_q.reg_write;
  assign MemWriteE      = stage_q.mem_write;
  assign ResultSrcE     = stage_q.result_src;
  assign JumpE          = stage_q.jump;
  assign BranchE        = stage_q.branch;
  assign ALUSrcE        = stage_q.alu_src;
  assign ALUSrcAE       = stage_q.alu_src_a;
  assign SumSrcE        = stage_q.sum_src;
  assign ControlSignalE = stage_q.control_signal;
  assign ALUControlE    = stage_q.alu_control;
  assign StoreSrcE      = stage_q.store_src;
  assign TypeBranchE    = stage_q.type_branch;
  assign LoadSrcE       = stage_q.load_src;
  assign RD1E           = stage_q.rd1;
  assign RD2E           = stage_q.rd2;
  assign Rs1E           = stage_q.rs1;
  assign Rs2E           = stage_q.rs2;
  assign RdE            = stage_q.rd;
  assign PCE            = stage_q.pc;
  assign PCPlus4E       = stage_q.pc_plus4;
  assign ImmExtE        = stage_q.imm_ext;
  assign ValidE         = stage_q.valid;
  assign BubbleCountE   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed scenarios plus random stall/flush/valid traffic
// against a behavioural model; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_register;

  logic clk = 1'b0;
  logic rst, StallE, FlushE, ValidD;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUSrcAD, SumSrcD, ControlSignalD;
  logic [1:0] ResultSrcD, StoreSrcD;
  logic [3:0] ALUControlD;
  logic [2:0] TypeBranchD, LoadSrcD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;

  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, SumSrcE, ControlSignalE, ValidE;
  logic [1:0] ResultSrcE, StoreSrcE;
  logic [3:0] ALUControlE;
  logic [2:0] TypeBranchE, LoadSrcE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCountE;

  logic s_RegWriteE, s_MemWriteE, s_JumpE, s_BranchE, s_ALUSrcE, s_ALUSrcAE, s_SumSrcE;
  logic s_ControlSignalE, s_ValidE;
  logic [1:0] s_ResultSrcE, s_StoreSrcE;
  logic [3:0] s_ALUControlE;
  logic [2:0] s_TypeBranchE, s_LoadSrcE;
  logic [31:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
  logic [4:0] s_Rs1E, s_Rs2E, s_RdE;
  logic [3:0] s_BubbleCountE;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUSrcAD(ALUSrcAD), .SumSrcD(SumSrcD),
    .ControlSignalD(ControlSignalD), .ALUControlD(ALUControlD), .StoreSrcD(StoreSrcD),
    .TypeBranchD(TypeBranchD), .LoadSrcD(LoadSrcD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .SumSrcE(SumSrcE),
    .ControlSignalE(ControlSignalE), .ALUControlE(ALUControlE), .StoreSrcE(StoreSrcE),
    .TypeBranchE(TypeBranchE), .LoadSrcE(LoadSrcE), .RD1E(RD1E), .RD2E(RD2E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .ValidE(ValidE), .BubbleCountE(BubbleCountE)
  );

  id_ex_register #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUSrcAD(ALUSrcAD), .SumSrcD(SumSrcD),
    .ControlSignalD(ControlSignalD), .ALUControlD(ALUControlD), .StoreSrcD(StoreSrcD),
    .TypeBranchD(TypeBranchD), .LoadSrcD(LoadSrcD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RegWriteE(s_RegWriteE), .MemWriteE(s_MemWriteE), .ResultSrcE(s_ResultSrcE),
    .JumpE(s_JumpE), .BranchE(s_BranchE), .ALUSrcE(s_ALUSrcE), .ALUSrcAE(s_ALUSrcAE),
    .SumSrcE(s_SumSrcE), .ControlSignalE(s_ControlSignalE), .ALUControlE(s_ALUControlE),
    .StoreSrcE(s_StoreSrcE), .TypeBranchE(s_TypeBranchE), .LoadSrcE(s_LoadSrcE),
    .RD1E(s_RD1E), .RD2E(s_RD2E), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE),
    .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .ImmExtE(s_ImmExtE),
    .ValidE(s_ValidE), .BubbleCountE(s_BubbleCountE)
  );

  wire [21:0] ctrl_d = {RegWriteD, MemWriteD, ResultSrcD, JumpD, BranchD, ALUSrcD, ALUSrcAD,
                        SumSrcD, ControlSignalD, ALUControlD, StoreSrcD, TypeBranchD, LoadSrcD};
  wire [159:0] data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD};
  wire [14:0]  idx_d  = {Rs1D, Rs2D, RdD};

  wire [21:0] ctrl_e = {RegWriteE, MemWriteE, ResultSrcE, JumpE, BranchE, ALUSrcE, ALUSrcAE,
                        SumSrcE, ControlSignalE, ALUControlE, StoreSrcE, TypeBranchE, LoadSrcE};
  wire [159:0] data_e = {RD1E, RD2E, PCE, PCPlus4E, ImmExtE};
  wire [14:0]  idx_e  = {Rs1E, Rs2E, RdE};

  wire [21:0] s_ctrl_e = {s_RegWriteE, s_MemWriteE, s_ResultSrcE, s_JumpE, s_BranchE,
                          s_ALUSrcE, s_ALUSrcAE, s_SumSrcE, s_ControlSignalE, s_ALUControlE,
                          s_StoreSrcE, s_TypeBranchE, s_LoadSrcE};
  wire [159:0] s_data_e = {s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE};
  wire [14:0]  s_idx_e  = {s_Rs1E, s_Rs2E, s_RdE};

  // Reference model: what the execute slot should hold, and bubbles seen since reset.
  logic [21:0]  exp_ctrl;
  logic [159:0] exp_data;
  logic [14:0]  exp_idx;
  logic         exp_valid;
  int           exp_cnt, exp_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_ctrl = '0; exp_data = '0; exp_idx = '0; exp_valid = 1'b0;
  endtask

  task automatic model_bubble();
    if (exp_cnt < 65535) exp_cnt++;
    if (exp_cnt4 < 15) exp_cnt4++;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
      exp_cnt = 0; exp_cnt4 = 0;
    end else if (FlushE) begin
      model_clear();
      model_bubble();
    end else if (!StallE) begin
      exp_ctrl = ctrl_d; exp_data = data_d; exp_idx = idx_d; exp_valid = ValidD;
      if (!ValidD) model_bubble();
    end
  endtask

  task automatic check_all();
    chk("ctrl", 256'(ctrl_e), 256'(exp_ctrl));
    chk("data", 256'(data_e), 256'(exp_data));
    chk("idx", 256'(idx_e), 256'(exp_idx));
    chk("valid", 256'(ValidE), 256'(exp_valid));
    chk("bubble_cnt", 256'(BubbleCountE), 256'(exp_cnt));
    chk("sat_payload", 256'({s_ctrl_e, s_data_e, s_idx_e, s_ValidE}),
        256'({exp_ctrl, exp_data, exp_idx, exp_valid}));
    chk("sat_cnt", 256'(s_BubbleCountE), 256'(exp_cnt4));
  endtask

  task automatic rand_d();
    {RegWriteD, MemWriteD, ResultSrcD, JumpD, BranchD, ALUSrcD, ALUSrcAD, SumSrcD,
     ControlSignalD, ALUControlD, StoreSrcD, TypeBranchD, LoadSrcD} = 22'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    ValidD = 1'($urandom);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    rand_d();
    model_clear(); exp_cnt = 0; exp_cnt4 = 0;

    // Reset held with random inputs and a running clock.
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step();
    end
    chk("reset_rd1", 256'(RD1E), 256'(0));
    rst = 1'b0;

    // Pass-through, then an asynchronous reset mid-cycle.
    rand_d();
    ValidD = 1'b1; RD1D = 32'hDEADBEEF;
    step();
    chk("load_rd1", 256'(RD1E), 256'(32'hDEADBEEF));
    rand_d();
    ValidD = 1'b1; RD1D = 32'h12345678; ImmExtD = 32'hFFFFF800; RdD = 5'd5;
    ALUControlD = 4'b0110;
    step();
    chk("pt_rd1", 256'(RD1E), 256'(32'h12345678));
    chk("pt_imm", 256'(ImmExtE), 256'(32'hFFFFF800));
    chk("pt_rd", 256'(RdE), 256'(5));
    chk("pt_aluctl", 256'(ALUControlE), 256'(4'b0110));
    chk("pt_valid", 256'(ValidE), 256'(1));
    chk("pt_cnt", 256'(BubbleCountE), 256'(0));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd1", 256'(RD1E), 256'(0));
    chk("async_rst_valid", 256'(ValidE), 256'(0));
    model_clear(); exp_cnt = 0; exp_cnt4 = 0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Stall holds; release loads the latest decode value.
    rand_d();
    ValidD = 1'b1; PCD = 32'h100;
    step();
    StallE = 1'b1;
    PCD = 32'h104; step();
    PCD = 32'h108; step();
    PCD = 32'h10C; step();
    chk("stall_pc", 256'(PCE), 256'(32'h100));
    StallE = 1'b0;
    step();
    chk("unstall_pc", 256'(PCE), 256'(32'h10C));

    // Flush wins over stall.
    do_reset();
    rand_d();
    ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; StallE = 1'b1; FlushE = 1'b1;
    step();
    chk("flush_regwrite", 256'(RegWriteE), 256'(0));
    chk("flush_memwrite", 256'(MemWriteE), 256'(0));
    chk("flush_valid", 256'(ValidE), 256'(0));
    chk("flush_cnt", 256'(BubbleCountE), 256'(1));
    StallE = 1'b0; FlushE = 1'b0;

    // Invalid decode slots count as bubbles.
    do_reset();
    rand_d(); ValidD = 1'b0; step();
    rand_d(); ValidD = 1'b0; step();
    chk("inv_valid", 256'(ValidE), 256'(0));
    chk("inv_cnt", 256'(BubbleCountE), 256'(2));
    rand_d(); ValidD = 1'b1; step();
    chk("inv_valid_back", 256'(ValidE), 256'(1));
    chk("inv_cnt_hold", 256'(BubbleCountE), 256'(2));

    // Saturation of the narrow counter.
    do_reset();
    FlushE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_d();
      step();
    end
    chk("sat_cnt4", 256'(s_BubbleCountE), 256'(15));
    chk("sat_cnt16", 256'(BubbleCountE), 256'(20));
    FlushE = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_d();
      ValidD = ($urandom_range(0, 3) != 0);
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 5) == 0);
      rst    = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
Decode-to-execute pipeline register of the 5-stage RV32 core. It sits directly downstream of the decode stage. It captures that stage's control bundle, operands, register indices, PC values and extended immediate on each rising clock edge, and presents them to the execute stage. It supports stall (hold), flush (bubble insertion for load-use hazards or taken branches/jumps), a valid tag, and a saturating bubble counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of operand, PC and immediate fields
REG_ADDR_WIDTH, 5, width of register index fields
CNT_WIDTH, 16, width of bubble counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
StallE  in  1  hold all E outputs
FlushE  in  1  load bubble next edge
ValidD  in  1  decode slot holds a real instruction
RegWriteD->RegWriteE  in/out  1  register write enable
MemWriteD->MemWriteE  in/out  1  memory write enable
ResultSrcD->ResultSrcE  in/out  2  writeback mux select
JumpD->JumpE  in/out  1  jump
BranchD->BranchE  in/out  1  branch
ALUSrcD->ALUSrcE  in/out  1  ALU B source
ALUSrcAD->ALUSrcAE  in/out  1  ALU A source
SumSrcD->SumSrcE  in/out  1  target adder source
ControlSignalD->ControlSignalE  in/out  1  decoder auxiliary flag
ALUControlD->ALUControlE  in/out  4  ALU operation
StoreSrcD->StoreSrcE  in/out  2  store width
TypeBranchD->TypeBranchE  in/out  3  branch condition
LoadSrcD->LoadSrcE  in/out  3  load width/sign
RD1D->RD1E, RD2D->RD2E  in/out  DATA_WIDTH  register operands
Rs1D->Rs1E, Rs2D->Rs2E, RdD->RdE  in/out  REG_ADDR_WIDTH  register indices (for forwarding)
PCD->PCE, PCPlus4D->PCPlus4E, ImmExtD->ImmExtE  in/out  DATA_WIDTH  PC, PC+4, immediate
ValidE  out  1  execute slot holds a real instruction
BubbleCountE  out  CNT_WIDTH  bubbles inserted since reset

Behaviour:
- rst asserted, at any time including mid-stall: every output, ValidE and BubbleCountE go to 0 immediately, without waiting for a clock edge. All-zero is the canonical NOP bubble (RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0).
- Priority at each rising edge: rst > FlushE > StallE > normal load.
- Normal load (FlushE=0, StallE=0): every E output takes its D value. ValidE takes ValidD. Latency is exactly 1 cycle.
- StallE=1, FlushE=0: all outputs, ValidE and BubbleCountE hold their values.
- FlushE=1, with StallE either 0 or 1: every E output and ValidE go to 0.
- Bubble counting: BubbleCountE increments by 1 when ValidE is loaded as 0, either by a flush or by a normal load with ValidD=0. It does not increment on stall or reset.
- Counter saturation: BubbleCountE saturates at 2^CNT_WIDTH-1 and never wraps.
- Fields are passed through without modification; no arithmetic or width conversion on data paths.
- No combinational path from any D input to any E output.

Test Plan:
- Reset: hold rst=1 with random D inputs, toggle clk → all outputs 0. Assert rst asynchronously mid-cycle after loading RD1D=0xDEADBEEF → RD1E=0 before the next edge.
- Pass-through: ValidD=1, RD1D=0x12345678, ImmExtD=0xFFFFF800, RdD=5, ALUControlD=4'b0110, one edge → outputs match and ValidE=1 after exactly one edge. BubbleCountE stays 0.
- Stall: load PCD=0x100, then StallE=1 for 3 edges with PCD=0x104/0x108/0x10C → PCE stays 0x100. Release stall → PCE=0x10C next edge.
- Flush beats stall: StallE=1 and FlushE=1 together with RegWriteD=1 → RegWriteE=0, MemWriteE=0, ValidE=0, BubbleCountE increments to 1.
- Invalid decode: ValidD=0, FlushE=0 for 2 edges → ValidE=0, BubbleCountE=2. Then ValidD=1 → ValidE=1, count stays 2.
- Saturation: CNT_WIDTH=4, FlushE=1 for 20 edges → BubbleCountE stops at 15.
